// File: rtl/qspi_pkg.sv
// qspi_pkg: opcodes, FSM states and phase lengths shared by the quad-SPI XIP read path
package qspi_pkg;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_QREAD = 8'h6B;
  localparam int CMD_BITS = 8;
  localparam int ADDR_BITS = 24;
  localparam int DUMMY_SCK = 8;
  localparam int DATA_BITS = 32;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP} qspi_state_t;
endpackage

// File: rtl/qspi_xip_ctrl_if.sv
// qspi_xip_ctrl_if: CPU-side valid/ready word-read bus into the XIP controller
interface qspi_xip_ctrl_if;
  logic mem_valid;
  logic [25:0] mem_addr;
  logic mem_ready;
  logic [31:0] mem_rdata;
  modport master(output mem_valid, mem_addr, input mem_ready, mem_rdata);
  modport slave(input mem_valid, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/qspi_sck_gen.sv
// qspi_sck_gen: CLK_DIV prescaler producing mode-0 sck plus rise/fall strobes for the edge about to happen
module qspi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input logic clk,
  input logic resetn,
  input logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);
  // Preloading two below zero gives two extra clk of cs-to-first-edge setup
  localparam logic [8:0] LEAD = 9'h1FE;
  logic [8:0] cnt;
  logic tick;
  assign tick = en && cnt == 9'(CLK_DIV - 1);
  assign rise_tick = tick && !sck;
  assign fall_tick = tick && sck;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= LEAD;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= LEAD;
      sck <= 1'b0;
    end else begin
      cnt <= tick ? 9'd0 : cnt + 9'd1;
      sck <= sck ^ tick;
    end
endmodule

// File: rtl/qspi_xip_ctrl.sv
// qspi_xip_ctrl: turns one 32-bit bus read into a complete single/quad flash read transaction
module qspi_xip_ctrl import qspi_pkg::*; #(
  parameter int CLK_DIV = 1,
  parameter int CS_HIGH_CYC = 4
) (
  input logic clk,
  input logic resetn,
  input logic quad_en,
  qspi_xip_ctrl_if.slave mem,
  output logic busy,
  output logic qspi_sck,
  output logic [3:0] qspi_cs_n,
  output logic [3:0] qspi_dq_o,
  output logic [3:0] qspi_dq_oe,
  input logic [3:0] qspi_dq_i
);
  qspi_state_t state;
  logic quad;
  logic [1:0] cs_sel;
  logic [31:0] tx, rx;
  logic [5:0] bcnt;
  logic [7:0] gcnt;
  logic active, serial_out, rise_tick, fall_tick, last;
  assign active = state inside {CMD, ADDR, DUMMY, DATA};
  assign serial_out = state == CMD || state == ADDR;
  assign busy = state != IDLE;
  assign mem.mem_ready = state == DONE;
  assign qspi_cs_n = active ? ~(4'b0001 << cs_sel) : 4'hF;
  assign qspi_dq_o = {3'b000, serial_out && tx[31]};
  assign qspi_dq_oe = {3'b000, serial_out || (state == DATA && !quad)};
  assign last = bcnt == (state == CMD ? 6'(CMD_BITS - 1) :
                         state == ADDR ? 6'(ADDR_BITS - 1) :
                         state == DUMMY ? 6'(DUMMY_SCK - 1) :
                         quad ? 6'(DATA_BITS / 4 - 1) : 6'(DATA_BITS - 1));
  qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk(clk),
    .resetn(resetn),
    .en(active),
    .sck(qspi_sck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );
  // Opcode and address share one 32-bit shifter since both go out MSB first on dq0
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      quad <= 1'b0;
      cs_sel <= 2'd0;
      tx <= '0;
      rx <= '0;
      bcnt <= '0;
      gcnt <= '0;
      mem.mem_rdata <= '0;
    end else begin
      if (rise_tick && state == DATA) rx <= quad ? {rx[27:0], qspi_dq_i} : {rx[30:0], qspi_dq_i[1]};
      if (fall_tick) begin
        tx <= tx << 1;
        bcnt <= last ? 6'd0 : bcnt + 6'd1;
      end
      case (state)
        IDLE: if (mem.mem_valid) begin
          state <= CMD;
          quad <= quad_en;
          cs_sel <= mem.mem_addr[25:24];
          tx <= {quad_en ? OPC_QREAD : OPC_READ, mem.mem_addr[23:0] & 24'hFFFFFC};
        end
        CMD: if (fall_tick && last) state <= ADDR;
        ADDR: if (fall_tick && last) state <= quad ? DUMMY : DATA;
        DUMMY: if (fall_tick && last) state <= DATA;
        DATA: if (fall_tick && last) begin
          state <= DONE;
          mem.mem_rdata <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        end
        DONE: begin
          state <= GAP;
          gcnt <= 8'd0;
        end
        GAP: if (gcnt == 8'(CS_HIGH_CYC - 1)) state <= IDLE;
          else gcnt <= gcnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_qspi_xip_ctrl.sv
// tb_qspi_xip_ctrl: directed reads against a behavioural flash on CS0, plus a CLK_DIV=3 back-to-back instance
`timescale 1ns/1ps
module tb_qspi_xip_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  qspi_xip_ctrl_if mem ();
  qspi_xip_ctrl_if mem3 ();
  logic quad_en = 1'b0;
  logic busy, qspi_sck;
  logic [3:0] qspi_cs_n, qspi_dq_o, qspi_dq_oe;
  logic [3:0] qspi_dq_i = 4'hF;
  logic busy3, sck3;
  logic [3:0] cs_n3, dq_o3, dq_oe3;
  qspi_xip_ctrl #(.CLK_DIV(1), .CS_HIGH_CYC(4)) dut (
    .clk(clk), .resetn(resetn), .quad_en(quad_en), .mem(mem), .busy(busy),
    .qspi_sck(qspi_sck), .qspi_cs_n(qspi_cs_n), .qspi_dq_o(qspi_dq_o),
    .qspi_dq_oe(qspi_dq_oe), .qspi_dq_i(qspi_dq_i)
  );
  qspi_xip_ctrl #(.CLK_DIV(3), .CS_HIGH_CYC(4)) dut3 (
    .clk(clk), .resetn(resetn), .quad_en(1'b0), .mem(mem3), .busy(busy3),
    .qspi_sck(sck3), .qspi_cs_n(cs_n3), .qspi_dq_o(dq_o3),
    .qspi_dq_oe(dq_oe3), .qspi_dq_i(4'h0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default: return {a[3:0], ~a[3:0]};
    endcase
  endfunction
  int nrise = 0;
  int j;
  logic [31:0] sh = '0;
  logic [7:0] cap_op = '0;
  logic [7:0] fb;
  logic [23:0] cap_addr = '0;
  logic oe_seen = 1'b0;
  // Flash on CS0: samples dq0 on sck rise, drives read data after sck fall
  always @(posedge qspi_sck or negedge qspi_sck or posedge qspi_cs_n[0]) begin
    if (qspi_cs_n[0]) begin
      nrise = 0;
      qspi_dq_i = 4'hF;
    end else if (qspi_sck) begin
      nrise++;
      if (nrise == 1) oe_seen = 1'b0;
      if (nrise <= 32) sh = {sh[30:0], qspi_dq_o[0]};
      if (nrise == 32) begin
        cap_op = sh[31:24];
        cap_addr = sh[23:0];
      end else if (nrise > 32) oe_seen = oe_seen | (|qspi_dq_oe);
    end else if (cap_op == 8'h6B) begin
      if (nrise >= 40 && nrise < 48) begin
        j = nrise - 40;
        fb = fbyte(cap_addr + 24'(j / 2));
        qspi_dq_i = (j % 2 == 0) ? fb[7:4] : fb[3:0];
      end
    end else if (nrise >= 32 && nrise < 64) begin
      j = nrise - 32;
      fb = fbyte(cap_addr + 24'(j / 8));
      qspi_dq_i = {2'b11, fb[7 - (j % 8)], 1'b1};
    end
  end
  logic [31:0] rd;
  int lat;
  logic cs_ok;
  task automatic do_read(input logic q, input logic [25:0] a, input logic [3:0] cs_exp);
    repeat (8) @(negedge clk);
    quad_en = q;
    mem.mem_addr = a;
    mem.mem_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    cs_ok = 1'b1;
    rd = 'x;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (mem.mem_ready) begin
        lat = k;
        rd = mem.mem_rdata;
        break;
      end
      if (qspi_cs_n !== cs_exp) cs_ok = 1'b0;
    end
    mem.mem_valid = 1'b0;
  endtask
  int t_rdy1, t_rdy2, t_idle, gap, n_rdy;
  initial begin
    mem.mem_valid = 1'b0;
    mem.mem_addr = '0;
    mem3.mem_valid = 1'b0;
    mem3.mem_addr = '0;
    #1 resetn = 1'b0;
    #2;
    check("rst_ready", mem.mem_ready, 0);
    check("rst_rdata", mem.mem_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_sck", qspi_sck, 0);
    check("rst_cs_n", qspi_cs_n, 4'hF);
    check("rst_dq_o", qspi_dq_o, 0);
    check("rst_dq_oe", qspi_dq_oe, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    do_read(1'b0, 26'h0000100, 4'hE);
    check("single_data", rd, 32'h44332211);
    check("single_lat", lat, 130);
    check("single_cs", cs_ok, 1);
    check("single_op", cap_op, 8'h03);
    check("single_addr", cap_addr, 24'h000100);
    repeat (20) @(negedge clk);
    check("rdata_hold", mem.mem_rdata, 32'h44332211);
    check("idle_busy", busy, 0);
    do_read(1'b1, 26'h0000100, 4'hE);
    check("quad_data", rd, 32'h44332211);
    check("quad_lat", lat, 98);
    check("quad_cs", cs_ok, 1);
    check("quad_op", cap_op, 8'h6B);
    check("quad_oe", oe_seen, 0);
    do_read(1'b0, 26'h2000100, 4'hB);
    check("cs2_data", rd, 32'hFFFFFFFF);
    check("cs2_lat", lat, 130);
    check("cs2_cs", cs_ok, 1);
    do_read(1'b0, 26'h0000103, 4'hE);
    check("lowbits_addr", cap_addr, 24'h000100);
    check("lowbits_data", rd, 32'h44332211);
    do_read(1'b1, 26'h0000104, 4'hE);
    check("quad104_data", rd, 32'h78695A4B);
    check("quad104_addr", cap_addr, 24'h000104);
    do_read(1'b0, 26'h0FFFFFC, 4'hE);
    check("top_data", rd, 32'hF0E1D2C3);
    check("top_addr", cap_addr, 24'hFFFFFC);
    repeat (8) @(negedge clk);
    quad_en = 1'b0;
    mem.mem_addr = 26'h0000100;
    mem.mem_valid = 1'b1;
    repeat (30) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_cs_n", qspi_cs_n, 4'hF);
    check("midrst_sck", qspi_sck, 0);
    check("midrst_oe", qspi_dq_oe, 0);
    check("midrst_busy", busy, 0);
    mem.mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    do_read(1'b0, 26'h0000100, 4'hE);
    check("postrst_data", rd, 32'h44332211);
    check("postrst_lat", lat, 130);
    @(negedge clk);
    mem3.mem_addr = 26'h0000100;
    mem3.mem_valid = 1'b1;
    @(posedge clk);
    t_rdy1 = -1;
    t_rdy2 = -1;
    t_idle = -1;
    gap = 0;
    n_rdy = 0;
    for (int k = 1; k <= 1500; k++) begin
      @(posedge clk);
      #1;
      if (n_rdy == 1 && busy3 && !mem3.mem_ready && cs_n3 == 4'hF) gap++;
      if (n_rdy == 1 && !busy3 && t_idle < 0) t_idle = k;
      if (mem3.mem_ready) begin
        if (n_rdy == 0) t_rdy1 = k;
        else t_rdy2 = k;
        n_rdy++;
      end
      if (n_rdy == 2) break;
    end
    mem3.mem_valid = 1'b0;
    check("b2b_lat1", t_rdy1, 386);
    check("b2b_gap", gap, 4);
    check("b2b_lat2", t_rdy2 - t_idle - 1, 386);
    check("b2b_data", mem3.mem_rdata, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qspi_xip_ctrl.md
Name: qspi_xip_ctrl

Overview:
- Execute-in-place read controller that sequences the chip's quad-SPI flash port (W25Q16JV-class parts) on behalf of the CPU memory bus.
- Converts a 32-bit word read on a valid/ready bus into one complete flash read transaction: command, 24-bit address, optional dummy cycles, then 4 data bytes.
- Drives sck, the four chip selects and the dq0..dq3 pads, with separate output-enable control on each dq pad.
- Sits between the core's memory interconnect and the qspi pad ring.

Parameters:
- CLK_DIV, 1, sck half-period in clk cycles; legal range 1..255.
- CS_HIGH_CYC, 4, minimum clk cycles all cs_n are held high between transactions; legal range 1..255.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- quad_en  in  1  0: read opcode 0x03, single lane; 1: read opcode 0x6B, quad output; must be static while busy
- mem_valid  in  1  read request; held high until mem_ready
- mem_addr  in  26  [25:24] chip select, [23:2] flash word address, [1:0] ignored
- mem_ready  out  1  one-cycle pulse marking mem_rdata valid
- mem_rdata  out  32  read word, little-endian byte assembly
- busy  out  1  high from acceptance until the CS-high gap ends
- qspi_sck  out  1  serial clock, SPI mode 0
- qspi_cs_n  out  4  one-hot-low chip selects
- qspi_dq_o  out  4  pad output data
- qspi_dq_oe  out  4  pad output enables
- qspi_dq_i  in  4  pad input data

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, busy=0, qspi_sck=0, qspi_cs_n=4'hF, qspi_dq_o=0, qspi_dq_oe=4'b0000. The FSM returns to IDLE.
- Reset taken mid-transaction: outputs go to reset values immediately and asynchronously. The flash aborts on cs_n rising; no recovery sequence is issued.
- FSM states: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> DONE -> GAP -> IDLE.
- IDLE: when mem_valid=1, latch the address with bits [1:0] forced to 0, latch quad_en, and assert busy. Next cycle, drive cs_n[mem_addr[25:24]] low.
- CMD: 8 opcode bits, MSB first, on dq0. dq_oe=4'b0001.
- ADDR: 24 address bits, MSB first, on dq0.
- DUMMY: quad only, 8 sck cycles. dq_oe=0.
- DATA:
  - Single lane: 32 bits sampled on dq1, dq_oe=4'b0001 with dq0 held at 0.
  - Quad: 8 nibbles sampled on dq[3:0], high nibble first, dq_oe=0.
- Clocking, SPI mode 0:
  - sck idles low.
  - Each sck phase lasts CLK_DIV clk cycles.
  - Output data changes with the sck falling edge; the first bit is set up before the first rising edge.
  - Input is sampled on the clk edge that drives sck high.
- Byte assembly: the first received byte goes to mem_rdata[7:0], the fourth to [31:24].
- Latency: mem_ready pulses exactly 2 + 2*CLK_DIV*N clk cycles after the mem_valid sampling edge.
  - N=64 single lane, N=48 quad.
  - With CLK_DIV=1: 130 cycles single, 98 cycles quad.
- DONE: cs_n rises, sck=0, dq_oe=0, and mem_ready pulses in the same cycle. mem_rdata holds its value until the next mem_ready.
- GAP: CS_HIGH_CYC cycles with all cs_n high, then busy=0 and the FSM enters IDLE.
  - A mem_valid held high through the gap is accepted on the first IDLE cycle.
- mem_valid dropping mid-transaction is a protocol violation. The transaction still completes and mem_ready still pulses.
- Changes to mem_addr while busy are ignored.
- The address counter wraps naturally at 24 bits. The controller never crosses a word within one transaction.

Decomposition:
- Package qspi_pkg:
  - Opcode constants OPC_READ=8'h03 and OPC_QREAD=8'h6B.
  - State enum qspi_state_t.
  - Bit-count constants: CMD_BITS=8, ADDR_BITS=24, DUMMY_SCK=8, DATA_BITS=32.
- One sub-module, qspi_sck_gen: CLK_DIV prescaler producing qspi_sck plus one-cycle rise_tick and fall_tick strobes, enabled by the FSM.
- The shift registers and FSM stay in qspi_xip_ctrl.

Test Plan:
- Single-lane read: flash preloaded with bytes 11 22 33 44 at 0x000100; quad_en=0, mem_addr=0x0000100 -> mem_rdata=0x44332211, mem_ready exactly 130 clk after acceptance (CLK_DIV=1); cs_n[0] low throughout the transaction; serial stream on dq0 is 0x03 then 0x000100.
- Quad read: same data at 0x000100, quad_en=1 -> rdata=0x44332211 after 98 clk; dq_oe=0 during DUMMY and DATA; opcode on dq0 is 0x6B.
- Chip select decode: mem_addr=0x2000100 -> only cs_n[2] asserts; cs_n[0] stays high; with no flash on CS2, rdata equals the pulled-up input pattern, e.g. 0xFFFFFFFF.
- Back-to-back reads with CLK_DIV=3, CS_HIGH_CYC=4 and mem_valid held high: all cs_n high for exactly 4 cycles between transactions; second mem_ready arrives 2+6*64 cycles after the second acceptance.
- Ignored address bits: mem_addr=0x0000103 -> transmitted address is 0x000100 and rdata=0x44332211.
- Reset mid-transaction: resetn low during ADDR -> same cycle cs_n=F, sck=0, dq_oe=0, busy=0; after release, a fresh read returns correct data.
